// File: rtl/mux_sel_sequencer.sv
// Serializes 4-bit words onto a 4:1 mux by stepping its select, with per-bit hold and pause.
// Optional macro SEL_MSB_FIRST_EN streams MSB-first (select counts 3..0) instead of LSB-first.
module mux_sel_sequencer #(
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [3:0] s_data,
    input  logic       pause,
    output logic [3:0] mux_in,
    output logic [1:0] mux_sel,
    output logic       bit_valid,
    output logic       bit_last,
    output logic       busy
);

`ifdef SEL_MSB_FIRST_EN
    localparam logic [1:0] SEL_START = 2'd3;
    localparam logic [1:0] SEL_END   = 2'd0;
`else
    localparam logic [1:0] SEL_START = 2'd0;
    localparam logic [1:0] SEL_END   = 2'd3;
`endif

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       sel_next;
    logic             hold_done;
    logic             at_end;
    logic             accept;

`ifdef SEL_MSB_FIRST_EN
    assign sel_next = mux_sel - 2'd1;
`else
    assign sel_next = mux_sel + 2'd1;
`endif

    assign hold_done = (hold_cnt == HOLD_LAST);
    assign at_end    = (mux_sel == SEL_END);

    // The final hold cycle of the last bit doubles as the accept slot, so words chain with no bubble.
    assign s_ready = !pause && ((state == IDLE) || ((state == SHIFT) && at_end && hold_done));
    assign accept  = s_valid && s_ready;

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            mux_in    <= 4'b0000;
            mux_sel   <= 2'b00;
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            state     <= SHIFT;
            hold_cnt  <= '0;
            mux_in    <= s_data;
            mux_sel   <= SEL_START;
            bit_valid <= 1'b1;
            bit_last  <= 1'b0;
            busy      <= 1'b1;
        end else if ((state == SHIFT) && !pause) begin
            if (!hold_done) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end else begin
                hold_cnt <= '0;
                if (!at_end) begin
                    mux_sel  <= sel_next;
                    bit_last <= (sel_next == SEL_END);
                end else begin
                    // mux_in keeps the last word; only the select returns to its idle value.
                    state     <= IDLE;
                    mux_sel   <= 2'b00;
                    bit_valid <= 1'b0;
                    bit_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: two instances (hold 1 and 2) against a position-based reference model.
// Honours SEL_MSB_FIRST_EN in the same way as the design.
module tb_mux_sel_sequencer;

    localparam int H0 = 1;
    localparam int H1 = 2;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       s_valid = 1'b0;
    logic [3:0] s_data  = 4'h0;
    logic       pause   = 1'b0;

    logic       rdy [2];
    logic [3:0] m_in [2];
    logic [1:0] m_sel [2];
    logic       bv [2];
    logic       bl [2];
    logic       bz [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mux_sel_sequencer #(.HOLD_CYCLES(H0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy[0]), .s_data(s_data),
        .pause(pause), .mux_in(m_in[0]), .mux_sel(m_sel[0]), .bit_valid(bv[0]),
        .bit_last(bl[0]), .busy(bz[0])
    );

    mux_sel_sequencer #(.HOLD_CYCLES(H1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy[1]), .s_data(s_data),
        .pause(pause), .mux_in(m_in[1]), .mux_sel(m_sel[1]), .bit_valid(bv[1]),
        .bit_last(bl[1]), .busy(bz[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word occupies positions 0 .. 4*H-1; bit index = position / H.
    bit         md_act [2]  = '{1'b0, 1'b0};
    logic [3:0] md_word [2] = '{4'h0, 4'h0};
    int         md_pos [2]  = '{0, 0};

    function automatic int hold_of(input int i);
        return (i == 0) ? H0 : H1;
    endfunction

    function automatic bit md_ready(input int i);
        return !pause && (!md_act[i] || (md_pos[i] == 4 * hold_of(i) - 1));
    endfunction

    function automatic logic [1:0] md_sel(input int i);
        int idx;
        if (!md_act[i]) return 2'b00;
        idx = md_pos[i] / hold_of(i);
`ifdef SEL_MSB_FIRST_EN
        return 2'(3 - idx);
`else
        return 2'(idx);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                md_act[i]  = 1'b0;
                md_word[i] = 4'h0;
                md_pos[i]  = 0;
            end else if (s_valid && md_ready(i)) begin
                md_act[i]  = 1'b1;
                md_word[i] = s_data;
                md_pos[i]  = 0;
            end else if (md_act[i] && !pause) begin
                if (md_pos[i] == 4 * hold_of(i) - 1) md_act[i] = 1'b0;
                else md_pos[i]++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("d%0d s_ready", i), 32'(rdy[i]), 32'(md_ready(i)));
                check($sformatf("d%0d mux_in", i), 32'(m_in[i]), 32'(md_word[i]));
                check($sformatf("d%0d mux_sel", i), 32'(m_sel[i]), 32'(md_sel(i)));
                check($sformatf("d%0d bit_valid", i), 32'(bv[i]), 32'(md_act[i]));
                check($sformatf("d%0d busy", i), 32'(bz[i]), 32'(md_act[i]));
                check($sformatf("d%0d bit_last", i), 32'(bl[i]),
                      32'(md_act[i] && (md_pos[i] / hold_of(i) == 3)));
                if (md_act[i])
                    check($sformatf("d%0d stream_bit", i), 32'(m_in[i][m_sel[i]]),
                          32'(md_word[i][md_sel(i)]));
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] d, input logic p);
        s_valid = v;
        s_data  = d;
        pause   = p;
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s d%0d mux_in", tag, i), 32'(m_in[i]), 32'h0);
            check($sformatf("%s d%0d mux_sel", tag, i), 32'(m_sel[i]), 32'h0);
            check($sformatf("%s d%0d bit_valid", tag, i), 32'(bv[i]), 32'h0);
            check($sformatf("%s d%0d bit_last", tag, i), 32'(bl[i]), 32'h0);
            check($sformatf("%s d%0d busy", tag, i), 32'(bz[i]), 32'h0);
        end
    endtask

    logic [1:0] seq [4];
    logic       bits_1010 [4];

    initial begin
`ifdef SEL_MSB_FIRST_EN
        seq       = '{2'd3, 2'd2, 2'd1, 2'd0};
        bits_1010 = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        seq       = '{2'd0, 2'd1, 2'd2, 2'd3};
        bits_1010 = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        // Reset held for three cycles.
        drive(1'b0, 4'h0, 1'b0);
        repeat (3) cycle();
        check_reset_values("reset");
        check("reset d0 s_ready", 32'(rdy[0]), 32'h1);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        cycle();

        // Single word 1010: hold 1 steps every cycle, hold 2 every other cycle.
        drive(1'b1, 4'b1010, 1'b0);
        cycle();
        drive(1'b0, 4'h0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            if (j < 4) begin
                check("single d0 mux_in", 32'(m_in[0]), 32'hA);
                check("single d0 mux_sel", 32'(m_sel[0]), 32'(seq[j]));
                check("single d0 out", 32'(m_in[0][m_sel[0]]), 32'(bits_1010[j]));
                check("single d0 bit_last", 32'(bl[0]), 32'(j == 3));
            end else if (j == 4) begin
                check("single d0 idle bit_valid", 32'(bv[0]), 32'h0);
                check("single d0 idle mux_sel", 32'(m_sel[0]), 32'h0);
            end
            check("hold2 d1 mux_sel", 32'(m_sel[1]), 32'(seq[j / 2]));
            check("hold2 d1 bit_valid", 32'(bv[1]), 32'h1);
            check("hold2 d1 s_ready", 32'(rdy[1]), 32'(j == 7));
            cycle();
        end
        check("hold2 d1 idle bit_valid", 32'(bv[1]), 32'h0);
        repeat (2) cycle();

        // Back-to-back C then 3 on the hold-1 instance.
        check("b2b d0 ready cycle0", 32'(rdy[0]), 32'h1);
        drive(1'b1, 4'hC, 1'b0);
        cycle();
        for (int j = 0; j < 8; j++) begin
            drive(j <= 3, 4'h3, 1'b0);
            check("b2b d0 bit_valid", 32'(bv[0]), 32'h1);
            check("b2b d0 mux_in", 32'(m_in[0]), (j < 4) ? 32'hC : 32'h3);
            check("b2b d0 s_ready", 32'(rdy[0]), 32'((j == 3) || (j == 7)));
            cycle();
        end
        drive(1'b0, 4'h0, 1'b0);
        repeat (12) cycle();

        // Pause for three cycles while the hold-1 instance sits at its second bit.
        drive(1'b1, 4'h5, 1'b0);
        cycle();
        drive(1'b0, 4'h0, 1'b0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'h0, 1'b1);
            check("pause d0 s_ready", 32'(rdy[0]), 32'h0);
            check("pause d0 mux_sel", 32'(m_sel[0]), 32'(seq[1]));
            check("pause d0 bit_valid", 32'(bv[0]), 32'h1);
            cycle();
        end
        drive(1'b0, 4'h0, 1'b0);
        check("pause held d0 mux_sel", 32'(m_sel[0]), 32'(seq[1]));
        cycle();
        check("resume d0 mux_sel", 32'(m_sel[0]), 32'(seq[2]));
        repeat (12) cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'hF, 1'b1);
            cycle();
            check("idle pause d0 busy", 32'(bz[0]), 32'h0);
            check("idle pause d1 busy", 32'(bz[1]), 32'h0);
        end
        drive(1'b0, 4'h0, 1'b0);
        cycle();

        // Asynchronous reset between edges while the hold-1 instance is at its third bit.
        drive(1'b1, 4'h9, 1'b0);
        cycle();
        drive(1'b0, 4'h0, 1'b0);
        repeat (2) cycle();
        check("pre-reset d0 mux_sel", 32'(m_sel[0]), 32'(seq[2]));
        #1 rst_n = 1'b0;
        #1 check_reset_values("async");
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive(1'b1, 4'hF, 1'b0);
        cycle();
        drive(1'b0, 4'h0, 1'b0);
        check("post-reset d0 mux_sel", 32'(m_sel[0]), 32'(seq[0]));
        check("post-reset d0 mux_in", 32'(m_in[0]), 32'hF);
        check("post-reset d0 bit_valid", 32'(bv[0]), 32'h1);
        repeat (10) cycle();

        // Randomized traffic with one asynchronous reset pulse in the middle.
        for (int n = 0; n < 4000; n++) begin
            drive($urandom_range(99) < 70, 4'($urandom), $urandom_range(99) < 15);
            if (n == 2000) begin
                #1 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
